// File: rtl/adder_pkg.sv
// Shared definitions for the serial adder: FSM state encoding and the
// digit-counter width helper.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-digit configuration still needs a 1-bit counter.
  function automatic int cnt_width(input int width, input int digit);
    int w;
    w = $clog2(width / digit);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_adder_fulladder.sv
// Single-bit full-adder cell, the building block of the per-cycle ripple chain.
module fulladder (
  output logic s,
  output logic c,
  input  logic a,
  input  logic b,
  input  logic cin
);

  assign s = a ^ b ^ cin;
  assign c = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: WIDTH-bit sum computed DIGIT bits per cycle, LSB first,
// through a registered carry, with a start/busy/done handshake.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = cnt_width(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $fatal(1, "serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [CW-1:0]    count;
  logic [DIGIT:0]   chain;
  logic [DIGIT-1:0] digit_sum;

  assign chain[0] = carry_q;

  for (genvar i = 0; i < DIGIT; i++) begin : g_chain
    fulladder u_fa (
      .s   (digit_sum[i]),
      .c   (chain[i+1]),
      .a   (a_q[i]),
      .b   (b_q[i]),
      .cin (chain[i])
    );
  end

  // DONE accepts a new start exactly like IDLE so operations can run back to back.
  // chain[DIGIT-1] is the carry into the MSB cell on the final digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      count    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            a_q      <= a;
            b_q      <= b;
            carry_q  <= cin;
            count    <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sum     <= WIDTH'({digit_sum, sum} >> DIGIT);
          carry_q <= chain[DIGIT];
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          count   <= count + 1'b1;
          if (count == LAST) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            cout     <= chain[DIGIT];
            overflow <= chain[DIGIT-1] ^ chain[DIGIT];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: one bit-serial and one 4-bit-digit
// instance share stimulus and are checked against an arithmetic model.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       cin;
  logic [7:0] a;
  logic [7:0] b;

  logic       busy1, done1, cout1, ovf1;
  logic [7:0] sum1;
  logic       busy4, done4, cout4, ovf4;
  logic [7:0] sum4;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1)
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ovf4)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Result packed as {sum, cout, overflow}; overflow from the signed-operand rule.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [8:0] full;
    full = {1'b0, x} + {1'b0, y} + 9'(c);
    return {full[7:0], full[8], (x[7] == y[7]) && (full[7] != x[7])};
  endfunction

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input logic [9:0] exp, input string tag);
    int lat1 = -1;
    int lat4 = -1;
    int pulses1 = 0;
    int busy_cyc = 0;
    logic [9:0] r1 = '0;
    logic [9:0] r4 = '0;
    @(negedge clk);
    a = ta; b = tb; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " busy_at_accept"}, 32'(busy1), 32'd1);
    if (busy1) busy_cyc++;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (busy1) busy_cyc++;
      if (done1) begin
        pulses1++;
        if (lat1 < 0) begin
          lat1 = k;
          r1 = {sum1, cout1, ovf1};
        end
      end
      if (done4 && lat4 < 0) begin
        lat4 = k;
        r4 = {sum4, cout4, ovf4};
      end
    end
    check({tag, " latency_d1"}, 32'(lat1), 32'd8);
    check({tag, " latency_d4"}, 32'(lat4), 32'd2);
    check({tag, " result_d1"}, 32'(r1), 32'(exp));
    check({tag, " result_d4"}, 32'(r4), 32'(exp));
    check({tag, " done_pulses"}, 32'(pulses1), 32'd1);
    check({tag, " busy_cycles"}, 32'(busy_cyc), 32'd8);
    check({tag, " result_held"}, 32'({sum1, cout1, ovf1}), 32'(exp));
  endtask

  task automatic applyStimulus();
    logic [7:0] x, y;
    logic       c;
    int         lat;
    int         pulses;

    vecs[0] = '{8'h01, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1};
    vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[7] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_d1", 32'({busy1, done1, sum1, cout1, ovf1}), 32'd0);
    check("reset_d4", 32'({busy4, done4, sum4, cout4, ovf4}), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].s, vecs[i].co, vecs[i].ov},
             $sformatf("vec%0d", i));

    // start pulsed mid-RUN with a different operand must be ignored
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 12 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (done1) lat = k;
      if (k == 3) begin
        a = 8'hAA; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("midrun_latency", 32'(lat), 32'd8);
    check("midrun_sum", 32'(sum1), 32'h30);
    repeat (4) @(posedge clk);

    // start during the DONE cycle is accepted back to back
    @(negedge clk);
    a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 12 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (done1) lat = k;
    end
    check("b2b_first_latency", 32'(lat), 32'd8);
    check("b2b_first_sum", 32'(sum1), 32'h07);
    a = 8'h05; b = 8'h06; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy_rises", 32'(busy1), 32'd1);
    lat = -1;
    for (int k = 1; k <= 12 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (done1) lat = k;
    end
    check("b2b_second_latency", 32'(lat), 32'd8);
    check("b2b_second_sum", 32'(sum1), 32'h0B);
    repeat (3) @(posedge clk);

    // asynchronous reset three cycles into RUN aborts the operation
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_outputs_d1", 32'({busy1, done1, sum1, cout1, ovf1}), 32'd0);
    check("abort_outputs_d4", 32'({busy4, done4, sum4, cout4, ovf4}), 32'd0);
    pulses = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done1) pulses++;
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'hFF, 8'hFF, 1'b0, {8'hFE, 1'b1, 1'b0}, "after_abort");

    for (int n = 0; n < 20; n++) begin
      x = 8'($urandom_range(0, 255));
      y = 8'($urandom_range(0, 255));
      c = 1'($urandom_range(0, 1));
      run_op(x, y, c, model(x, y, c), $sformatf("rand%0d", n));
    end
  endtask

  task automatic checkOutput();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
  endtask

  initial begin
    applyStimulus();
    checkOutput();
    $finish;
  end

endmodule
